// File: rtl/des_subkey_sequencer_if.sv
// rtl/des_subkey_sequencer_if.sv - request/subkey handshake bundle for the DES key-schedule sequencer
interface des_subkey_sequencer_if;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    modport master (
        output start, decrypt, key_in, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    modport slave (
        input  start, decrypt, key_in, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done
    );
endinterface

// File: rtl/des_subkey_sequencer.sv
// rtl/des_subkey_sequencer.sv - iterative DES key schedule, one subkey per handshake, encrypt or decrypt order
module des_subkey_sequencer (
    input  logic                         clk,
    input  logic                         rst,
    des_subkey_sequencer_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Tables hold FIPS bit numbers (1 = MSB of the source vector).
    localparam logic [5:0] PC1_TAB [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Bit k set when round k+1 rotates by two positions instead of one.
    localparam logic [15:0] TWO_MASK = 16'b0111_1110_1111_1100;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] res;
        logic [5:0]  idx;
        res = '0;
        for (int i = 0; i < 56; i++) begin
            idx = 6'd0 - PC1_TAB[i];
            res = {res[54:0], k[idx]};
        end
        return res;
    endfunction

    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] res;
        logic [5:0]  idx;
        cd  = {c, d};
        res = '0;
        for (int i = 0; i < 48; i++) begin
            idx = 6'd56 - PC2_TAB[i];
            res = {res[46:0], cd[idx]};
        end
        return res;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state;
    logic [27:0] c_q, d_q;
    logic [3:0]  step_q;
    logic        mode_q;
    logic [47:0] subkey_q;
    logic        valid_q;
    logic [3:0]  round_q;
    logic        busy_q;
    logic        done_q;

    logic [55:0] cd0;
    logic [27:0] c_src, d_src, c_nx, d_nx;
    logic        rot_en, rot_left, rot_two;
    logic [3:0]  round_nx;
    logic [47:0] subkey_nx;
    logic        xfer;

    assign xfer = valid_q && bus.subkey_ready;

    // Next rotation step: from PC1(key_in) when starting, else from the C/D registers.
    always_comb begin
        cd0      = pc1(bus.key_in);
        c_src    = c_q;
        d_src    = d_q;
        rot_en   = 1'b1;
        rot_left = !mode_q;
        rot_two  = 1'b0;
        round_nx = round_q;
        if (state == IDLE) begin
            c_src    = cd0[55:28];
            d_src    = cd0[27:0];
            rot_en   = !bus.decrypt;
            rot_left = 1'b1;
            rot_two  = TWO_MASK[0];
            round_nx = bus.decrypt ? 4'd15 : 4'd0;
        end else if (mode_q) begin
            rot_two  = TWO_MASK[~step_q];
            round_nx = round_q - 4'd1;
        end else begin
            rot_two  = TWO_MASK[step_q + 4'd1];
            round_nx = round_q + 4'd1;
        end

        if (!rot_en) begin
            c_nx = c_src;
            d_nx = d_src;
        end else if (rot_left) begin
            c_nx = rotl(c_src, rot_two);
            d_nx = rotl(d_src, rot_two);
        end else begin
            c_nx = rotr(c_src, rot_two);
            d_nx = rotr(d_src, rot_two);
        end
        subkey_nx = pc2(c_nx, d_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            step_q   <= '0;
            mode_q   <= 1'b0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            round_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mode_q   <= bus.decrypt;
                        c_q      <= c_nx;
                        d_q      <= d_nx;
                        step_q   <= '0;
                        subkey_q <= subkey_nx;
                        round_q  <= round_nx;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (step_q == 4'd15) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            round_q <= '0;
                            state   <= FIN;
                        end else begin
                            c_q      <= c_nx;
                            d_q      <= d_nx;
                            step_q   <= step_q + 4'd1;
                            subkey_q <= subkey_nx;
                            round_q  <= round_nx;
                        end
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.subkey       = subkey_q;
    assign bus.subkey_valid = valid_q;
    assign bus.round_idx    = round_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_des_subkey_sequencer.sv
// tb/tb_des_subkey_sequencer.sv - self-checking bench for des_subkey_sequencer against an array-based key-schedule model
module tb_des_subkey_sequencer;
    logic clk;
    logic rst;
    des_subkey_sequencer_if bus ();

    des_subkey_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] got_k [16];
    logic [3:0]  got_r [16];
    logic [47:0] saved_k [16];

    // Subkey of encrypt round rnd (1..16): rotate the PC-1 halves by the cumulative shift count.
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int rnd);
        bit c0 [28];
        bit d0 [28];
        bit cd [56];
        int rot;
        logic [47:0] r;
        rot = 0;
        for (int i = 0; i < rnd; i++) rot += shifts[i];
        for (int j = 0; j < 28; j++) begin
            c0[j] = key[64 - pc1_t[j]];
            d0[j] = key[64 - pc1_t[28 + j]];
        end
        for (int j = 0; j < 28; j++) begin
            cd[j]      = c0[(j + rot) % 28];
            cd[28 + j] = d0[(j + rot) % 28];
        end
        r = '0;
        for (int m = 0; m < 48; m++) r[47 - m] = cd[pc2_t[m] - 1];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.subkey_valid), 64'd0);
        check({tag, "_busy"},  64'(bus.busy), 64'd0);
        check({tag, "_done"},  64'(bus.done), 64'd0);
        check({tag, "_round"}, 64'(bus.round_idx), 64'd0);
    endtask

    // One full schedule with random backpressure; optional start/key disturbance mid-run and in FIN.
    task automatic run_sched(input logic [63:0] key, input bit dec, input int ready_pct, input bit disturb);
        int n;
        int cycles;
        bit rdy;
        logic [47:0] hold_k;
        logic [3:0]  hold_r;
        logic [47:0] exp_k;
        logic [3:0]  exp_r;
        bus.start   = 1'b1;
        bus.key_in  = key;
        bus.decrypt = dec;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        n = 0;
        cycles = 0;
        while (n < 16 && cycles < 500) begin
            cycles++;
            rdy = ($urandom_range(99) < 32'(ready_pct));
            bus.subkey_ready = rdy;
            if (disturb && n == 4) begin
                bus.start   = 1'b1;
                bus.key_in  = {$urandom, $urandom};
                bus.decrypt = ~dec;
            end else begin
                bus.start = 1'b0;
            end
            check("valid_in_run", 64'(bus.subkey_valid), 64'd1);
            check("done_in_run", 64'(bus.done), 64'd0);
            hold_k = bus.subkey;
            hold_r = bus.round_idx;
            if (rdy) begin
                exp_r = dec ? 4'(15 - n) : 4'(n);
                exp_k = model_subkey(key, int'(exp_r) + 1);
                check($sformatf("subkey_%0d", n), 64'(bus.subkey), 64'(exp_k));
                check($sformatf("round_%0d", n), 64'(bus.round_idx), 64'(exp_r));
                got_k[n] = bus.subkey;
                got_r[n] = bus.round_idx;
                n++;
            end
            tick();
            if (!rdy) begin
                check("hold_subkey", 64'(bus.subkey), 64'(hold_k));
                check("hold_round", 64'(bus.round_idx), 64'(hold_r));
            end
        end
        bus.start = 1'b0;
        check("transfers_done", 64'(n), 64'd16);
        check("fin_done", 64'(bus.done), 64'd1);
        check("fin_busy", 64'(bus.busy), 64'd0);
        check("fin_valid", 64'(bus.subkey_valid), 64'd0);
        check("fin_subkey_hold", 64'(bus.subkey), 64'(model_subkey(key, dec ? 1 : 16)));
        if (disturb) begin
            bus.start  = 1'b1;
            bus.key_in = {$urandom, $urandom};
        end
        tick();
        bus.start = 1'b0;
        check_idle_outputs("post_fin");
        if (disturb) begin
            tick();
            check_idle_outputs("no_second_run");
        end
    endtask

    logic [63:0] k;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.decrypt = 1'b0;
        bus.key_in = '0;
        bus.subkey_ready = 1'b0;
        repeat (2) tick();
        check("reset_subkey", 64'(bus.subkey), 64'd0);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Known-answer encrypt run, ready always high.
        bus.subkey_ready = 1'b1;
        bus.key_in  = 64'h133457799BBCDFF1;
        bus.decrypt = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check("kat_enc_k1", 64'(bus.subkey), 64'h1B02EFFC7072);
        check("kat_enc_r1", 64'(bus.round_idx), 64'd0);
        tick();
        check("kat_enc_k2", 64'(bus.subkey), 64'h79AED9DBC9E5);
        check("kat_enc_r2", 64'(bus.round_idx), 64'd1);
        repeat (14) tick();
        check("kat_enc_k16", 64'(bus.subkey), 64'hCB3D8B0E17F5);
        check("kat_enc_r16", 64'(bus.round_idx), 64'd15);
        check("kat_enc_valid16", 64'(bus.subkey_valid), 64'd1);
        tick();
        check("kat_enc_done", 64'(bus.done), 64'd1);
        check("kat_enc_busy", 64'(bus.busy), 64'd0);
        tick();
        check("kat_enc_done_pulse", 64'(bus.done), 64'd0);

        // Known-answer decrypt run: reverse order, round_idx counting down.
        run_sched(64'h133457799BBCDFF1, 1'b1, 100, 1'b0);
        check("kat_dec_first", 64'(got_k[0]), 64'hCB3D8B0E17F5);
        check("kat_dec_first_r", 64'(got_r[0]), 64'd15);
        check("kat_dec_penult", 64'(got_k[14]), 64'h79AED9DBC9E5);
        check("kat_dec_last", 64'(got_k[15]), 64'h1B02EFFC7072);
        check("kat_dec_last_r", 64'(got_r[15]), 64'd0);

        // Random keys, both modes, random backpressure.
        for (int t = 0; t < 6; t++) run_sched({$urandom, $urandom}, t[0], 70, 1'b0);

        // start / key_in / decrypt disturbance mid-run and in FIN; next run starts right after done.
        run_sched({$urandom, $urandom}, 1'b0, 70, 1'b1);
        run_sched({$urandom, $urandom}, 1'b1, 70, 1'b1);
        run_sched({$urandom, $urandom}, 1'b0, 100, 1'b0);
        run_sched({$urandom, $urandom}, 1'b1, 100, 1'b0);

        // Asynchronous reset at step 7 with valid high.
        bus.subkey_ready = 1'b1;
        bus.key_in  = {$urandom, $urandom};
        bus.decrypt = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        check("pre_abort_valid", 64'(bus.subkey_valid), 64'd1);
        check("pre_abort_round", 64'(bus.round_idx), 64'd6);
        #2 rst = 1'b1;
        #1;
        check("abort_subkey", 64'(bus.subkey), 64'd0);
        check_idle_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 64'(bus.done), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_idle_outputs("after_abort");
        run_sched({$urandom, $urandom}, 1'b0, 70, 1'b0);

        // Parity bits are ignored.
        k = {$urandom, $urandom};
        run_sched(k, 1'b0, 100, 1'b0);
        for (int i = 0; i < 16; i++) saved_k[i] = got_k[i];
        run_sched(k ^ 64'h0101010101010101, 1'b0, 70, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("parity_%0d", i), 64'(got_k[i]), 64'(saved_k[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
